// File: rtl/snn_spike_classifier.sv
// Integrates per-class spikes over a programmable window, then scans for the argmax class.
// Optional early exit on threshold crossing is enabled by defining SNN_CLS_EARLY_EXIT_EN.
module snn_spike_classifier #(
  parameter int OUTPUT_SIZE  = 10,
  parameter int CNT_WIDTH    = 8,
  parameter int WIN_WIDTH    = 16,
  parameter int EARLY_THRESH = 200
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIN_WIDTH-1:0]           window_len,
  input  logic [OUTPUT_SIZE-1:0]         digit_spikes,
  output logic                           busy,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [$clog2(OUTPUT_SIZE)-1:0] result_digit,
  output logic [CNT_WIDTH-1:0]           result_count,
  output logic                           result_tie
);

  localparam int IDX_W = $clog2(OUTPUT_SIZE);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);
`ifdef SNN_CLS_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, HOLD} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt      [OUTPUT_SIZE];
  logic [CNT_WIDTH-1:0] cnt_next [OUTPUT_SIZE];
  logic [WIN_WIDTH-1:0] n_len;
  logic [WIN_WIDTH-1:0] sample_cnt;
  logic [IDX_W-1:0]     scan_idx;
  logic [CNT_WIDTH-1:0] run_max;
  logic [IDX_W-1:0]     run_idx;
  logic                 run_tie;

  logic [CNT_WIDTH-1:0] scan_cnt;
  logic [CNT_WIDTH-1:0] max_next;
  logic [IDX_W-1:0]     idx_next;
  logic                 tie_next;
  logic                 crossed;
  logic                 early_exit;
  logic                 last_sample;

  // Saturating per-class increment; the threshold test looks at the post-update value.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    crossed = 1'b0;
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
      cnt_next[i] = cnt[i];
      if (digit_spikes[i] && (cnt[i] != CNT_MAX)) cnt_next[i] = cnt[i] + 1'b1;
      if (int'(cnt_next[i]) >= EARLY_THRESH) crossed = 1'b1;
    end
  end

  assign early_exit  = EARLY_EN && crossed;
  assign last_sample = (sample_cnt == n_len - 1'b1);
  assign scan_cnt    = cnt[scan_idx];

  // Strictly-greater updates the winner, so on equal counts the lowest index stays.
  always_comb begin
    max_next = run_max;
    idx_next = run_idx;
    tie_next = run_tie;
    if (scan_idx == '0) begin
      max_next = scan_cnt;
      idx_next = '0;
      tie_next = 1'b0;
    end else if (scan_cnt > run_max) begin
      max_next = scan_cnt;
      idx_next = scan_idx;
      tie_next = 1'b0;
    end else if (scan_cnt == run_max) begin
      tie_next = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is reset explicitly; a reset must discard any partial window.
      for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
      state        <= IDLE;
      n_len        <= '0;
      sample_cnt   <= '0;
      scan_idx     <= '0;
      run_max      <= '0;
      run_idx      <= '0;
      run_tie      <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_digit <= '0;
      result_count <= '0;
      result_tie   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
            sample_cnt <= '0;
            n_len      <= (window_len == '0) ? WIN_WIDTH'(1) : window_len;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          cnt        <= cnt_next;
          sample_cnt <= sample_cnt + 1'b1;
          if (last_sample || early_exit) begin
            scan_idx <= '0;
            state    <= DECIDE;
          end
        end
        DECIDE: begin
          run_max  <= max_next;
          run_idx  <= idx_next;
          run_tie  <= tie_next;
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == LAST_IDX) begin
            result_digit <= idx_next;
            result_count <= max_next;
            result_tie   <= tie_next;
            result_valid <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_spike_classifier.sv
// Directed bench for snn_spike_classifier: a reference model computes each window's expected
// result, pushes it to a scoreboard queue, and it is popped when result_valid appears.
module tb_snn_spike_classifier;

  localparam int OS  = 10;
  localparam int CW  = 8;
  localparam int WW  = 16;
  localparam int ET  = 200;
  localparam int IW  = $clog2(OS);
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WW-1:0] window_len;
  logic [OS-1:0] digit_spikes;
  logic          busy;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] result_digit;
  logic [CW-1:0] result_count;
  logic          result_tie;

  always #5 clk = ~clk;

  snn_spike_classifier #(
    .OUTPUT_SIZE(OS), .CNT_WIDTH(CW), .WIN_WIDTH(WW), .EARLY_THRESH(ET)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .window_len(window_len),
    .digit_spikes(digit_spikes), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_digit(result_digit),
    .result_count(result_count), .result_tie(result_tie)
  );

  typedef struct {
    int digit;
    int count;
    int tie;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy,         0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_digit"}, result_digit, 0);
    check({tag, "_count"}, result_count, 0);
    check({tag, "_tie"},   result_tie,   0);
  endtask

  function automatic logic [OS-1:0] pattern(input int pat, input int k);
    logic [OS-1:0] p;
    p = '0;
    case (pat)
      0: begin p[3] = 1'b1; if (k % 2 == 0) p[7] = 1'b1; end
      1: begin p[2] = 1'b1; p[5] = 1'b1; end
      2: p[9] = 1'b1;
      3: p = '1;
      4: p[4] = 1'b1;
      5: p[1] = 1'b1;
      default: p = OS'($urandom);
    endcase
    return p;
  endfunction

  // One full classification: start, feed samples, scoreboard, optional backpressure, handshake.
  task automatic run_window(input int wl, input int pat, input int hold);
    int            n, taken, cyc;
    int            mc[OS];
    bit            stop;
    logic [OS-1:0] p;
    exp_t          e, got;
    n = (wl == 0) ? 1 : wl;
    foreach (mc[i]) mc[i] = 0;
    @(negedge clk);
    window_len = WW'(wl);
    start      = 1'b1;
    cyc        = 0;
    @(negedge clk);
    start      = 1'b0;
    window_len = WW'($urandom);
    cyc        = 1;
    check("busy_after_start", busy, 1);
    taken = 0;
    stop  = 1'b0;
    while (!stop) begin
      p = pattern(pat, taken + 1);
      digit_spikes = p;
      for (int i = 0; i < OS; i++) if (p[i] && mc[i] < SAT) mc[i]++;
      taken++;
      if (taken == n) stop = 1'b1;
`ifdef SNN_CLS_EARLY_EXIT_EN
      for (int i = 0; i < OS; i++) if (mc[i] >= ET) stop = 1'b1;
`endif
      @(negedge clk);
      cyc++;
    end
    e.digit = 0;
    e.count = mc[0];
    e.tie   = 0;
    for (int i = 1; i < OS; i++) begin
      if (mc[i] > e.count) begin
        e.digit = i;
        e.count = mc[i];
        e.tie   = 0;
      end else if (mc[i] == e.count) begin
        e.tie = 1;
      end
    end
    e.lat = taken + OS + 1;
    exp_q.push_back(e);
    while (!result_valid && cyc < taken + OS + 50) begin
      digit_spikes = OS'($urandom);
      @(negedge clk);
      cyc++;
    end
    got = exp_q.pop_front();
    check("valid_seen", result_valid, 1);
    check("latency",    cyc,          got.lat);
    check("digit",      result_digit, got.digit);
    check("count",      result_count, got.count);
    check("tie",        result_tie,   got.tie);
    repeat (hold) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_valid", result_valid, 1);
      check("bp_busy",  busy,         1);
      check("bp_digit", result_digit, got.digit);
      check("bp_count", result_count, got.count);
      check("bp_tie",   result_tie,   got.tie);
    end
    start        = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    result_ready = 1'b0;
    check("post_hs_valid", result_valid, 0);
    check("post_hs_busy",  busy,         0);
    check("post_hs_digit", result_digit, got.digit);
    check("post_hs_count", result_count, got.count);
    @(negedge clk);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    result_ready = 1'b0;
    window_len   = '0;
    digit_spikes = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst          = 1'b0;
    result_ready = 1'b1;
    digit_spikes = '1;
    repeat (4) @(negedge clk);
    check("ready_no_valid_valid", result_valid, 0);
    check("ready_no_valid_busy",  busy,         0);
    result_ready = 1'b0;

    run_window(20,   0, 0);   // basic argmax
    run_window(10,   1, 0);   // tie, lowest index wins
    run_window(300,  2, 0);   // saturation
    run_window(0,    3, 0);   // zero-length window -> one sample
    run_window(12,   0, 15);  // backpressure
    run_window(15,   6, 2);   // random spikes
    run_window(1000, 4, 0);   // early-exit or full window depending on build

    // Reset during the fifth accumulation cycle of a 20-sample window.
    @(negedge clk);
    window_len = WW'(20);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      digit_spikes = pattern(5, 0);
      @(negedge clk);
    end
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    check("mid_reset_idle", busy, 0);
    run_window(20, 5, 0);     // no carry-over from the aborted window

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
